alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//  Registered, multi-function successor to the combinational datapath ALU.
//  Takes operands from the A register and the bus, runs single-cycle ops in
//  one clock and an iterative shift-add multiply over `word` clocks, then
//  returns result G plus status flags through a start/busy/done handshake.
//  Sits between the A register / bus and the G register in the CPU datapath.
//  Controlled by the control-unit FSM.
// PARAMETERS
//  word    16  operand/result width in bits (>=4, power of 2)
//  MUL_EN  1   1: MUL implemented; 0: MUL opcode behaves as NOP
// PORTS
//  clk     in   1     rising-edge clock
//  reset_n in   1     synchronous reset, active-low
//  start   in   1     request; sampled only while busy=0
//  alu_op  in   3     opcode, sampled with start
//  A       in   word  operand A, sampled with start
//  bus     in   word  operand B, sampled with start
//  G       out  word  result register
//  flag_z  out  1     result == 0
//  flag_n  out  1     G[word-1]
//  flag_c  out  1     carry / borrow / shift-out / mul-overflow
//  flag_v  out  1     signed overflow
//  busy    out  1     multiply in progress
//  done    out  1     one-cycle pulse: G and flags valid
// BEHAVIOUR
//  Reset: one clock, synchronous, reset_n=0 sampled at the edge.
//   G, all flags, busy, done = 0. State = IDLE.
//   Reset during MUL aborts it; no done is issued.
//  Opcodes:
//   000 NOP  G=A
//   001 ADD  G=A+bus
//   010 SUB  G=A-bus
//   011 AND
//   100 OR
//   101 XOR
//   110 SHL  G=A<<bus[log2(word)-1:0]
//   111 MUL  G=low word of A*bus, unsigned
//  States: IDLE, MUL.
//  IDLE, start=1, non-MUL op (or MUL with MUL_EN=0):
//   - G and flags load at that edge; done=1 for the next cycle only.
//   - busy stays 0. Latency 1 clock.
//   - start may be held high for back-to-back ops; one result per clock.
//  IDLE, start=1, MUL with MUL_EN=1:
//   - Latch multiplicand=A, multiplier=bus. acc (2*word bits)=0.
//   - count=word. busy=1 from the next cycle. Go to MUL.
//  MUL state, each clock:
//   - If multiplier[0]=1, add the multiplicand (shifted) into acc.
//   - Shift; count--.
//   - On the edge where the final iteration completes (word edges after start):
//     G=acc[word-1:0], flags update, done=1 for one cycle, busy=0, go to IDLE.
//   - start asserted while busy=1 is ignored and not queued.
//   - A and bus may change freely during MUL.
//  Flags (updated only on a done edge; otherwise hold):
//   - Z and N are taken from the new G.
//   - ADD: C = carry out of bit word-1. V = signed overflow.
//   - SUB: C = borrow (A<bus unsigned). V = signed overflow.
//   - SHL: C = last bit shifted out (0 if amount=0). V=0.
//   - MUL: C = (acc[2*word-1:word]!=0). V=0.
//   - NOP/AND/OR/XOR: C=0, V=0.
//  G and flags hold between results. done is never high two cycles for one MUL.
// TESTING (word=16)
//  1. Reset, then ADD A=16'hFFFF bus=16'h0001 -> next cycle done=1, G=0,
//     Z=1 C=1 V=0 N=0.
//  2. SUB A=16'h8000 bus=1 -> G=16'h7FFF, V=1 C=0 N=0.
//     Then SUB A=3 bus=5 -> G=16'hFFFE, C=1 N=1.
//  3. MUL A=300 bus=300 -> busy=1 for 16 cycles, done after 16 edges,
//     G=16'h5F90 (90000 mod 65536), C=1.
//     Second start during busy is ignored.
//  4. Back-to-back: XOR, SHL A=16'h8001 bus=1, AND on consecutive clocks
//     with start held -> three done pulses.
//     SHL gives G=16'h0002, C=1.
//  5. Start MUL A=7 bus=9. Pull reset_n low on cycle 5 -> next cycle
//     G=0, busy=0, done=0. No later done appears.
//  6. MUL_EN=0 build: MUL A=5 bus=6 -> 1-cycle done, G=5 (NOP).

Source files
------------

// File: rtl/alu_seq.sv
// Registered datapath ALU: single-cycle logic/arith/shift ops plus an iterative
// shift-add multiply, returning G and status flags through start/busy/done.
module alu_seq #(
  parameter int word   = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      alu_op,
  input  logic [word-1:0] A,
  input  logic [word-1:0] bus,
  output logic [word-1:0] G,
  output logic            flag_z,
  output logic            flag_n,
  output logic            flag_c,
  output logic            flag_v,
  output logic            busy,
  output logic            done
);

  // state  | meaning
  // S_IDLE | accepting requests; single-cycle ops complete here
  // S_MUL  | shift-add multiply iterating, one partial product per clock
  typedef enum logic {S_IDLE, S_MUL} state_t;

  localparam int LOG = $clog2(word);
  localparam int CW  = LOG + 1;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  state_t              state_q, state_d;
  logic [word-1:0]     g_q, g_d;
  logic                z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
  logic                done_q, done_d;
  logic [2*word-1:0]   mcand_q, mcand_d;
  logic [word-1:0]     mplr_q, mplr_d;
  logic [2*word-1:0]   acc_q, acc_d;
  logic [CW-1:0]       count_q, count_d;

  logic [word:0]       sum, diff, ext;
  logic [word-1:0]     alu_g;
  logic                alu_c, alu_v;
  logic [2*word-1:0]   acc_nxt;

  // Single-cycle result path; opcode 000 and (with MUL disabled) 111 pass A.
  always_comb begin
    sum   = {1'b0, A} + {1'b0, bus};
    diff  = {1'b0, A} - {1'b0, bus};
    ext   = {1'b0, A} << bus[LOG-1:0];
    alu_g = A;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_g = sum[word-1:0];
        alu_c = sum[word];
        alu_v = (A[word-1] == bus[word-1]) && (sum[word-1] != A[word-1]);
      end
      OP_SUB: begin
        alu_g = diff[word-1:0];
        alu_c = diff[word];
        alu_v = (A[word-1] != bus[word-1]) && (diff[word-1] != A[word-1]);
      end
      OP_AND: alu_g = A & bus;
      OP_OR:  alu_g = A | bus;
      OP_XOR: alu_g = A ^ bus;
      OP_SHL: begin
        alu_g = ext[word-1:0];
        alu_c = ext[word];
      end
      default: alu_g = A;
    endcase
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    v_d     = v_q;
    done_d  = 1'b0;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    count_d = count_q;
    acc_nxt = acc_q + (mplr_q[0] ? mcand_q : '0);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (MUL_EN && (alu_op == OP_MUL)) begin
            mcand_d = {{word{1'b0}}, A};
            mplr_d  = bus;
            acc_d   = '0;
            count_d = CW'(word);
            state_d = S_MUL;
          end else begin
            g_d    = alu_g;
            z_d    = (alu_g == '0);
            n_d    = alu_g[word-1];
            c_d    = alu_c;
            v_d    = alu_v;
            done_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d   = acc_nxt;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        count_d = count_q - CW'(1);
        // Final iteration: publish the low word straight from the adder output.
        if (count_q == CW'(1)) begin
          g_d     = acc_nxt[word-1:0];
          z_d     = (acc_nxt[word-1:0] == '0);
          n_d     = acc_nxt[word-1];
          c_d     = |acc_nxt[2*word-1:word];
          v_d     = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      v_q     <= v_d;
      done_q  <= done_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  assign G      = g_q;
  assign flag_z = z_q;
  assign flag_n = n_q;
  assign flag_c = c_q;
  assign flag_v = v_q;
  assign busy   = (state_q == S_MUL);
  assign done   = done_q;

endmodule
